// File: rtl/scoreboard_if.sv
// Issue/retire handshake bundle between the decode/pipeline control and the scoreboard.
interface scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       issue_rs1_used;
  logic       issue_rs2_used;
  logic [4:0] issue_rd;
  logic       issue_wb_en;
  logic       issue_is_load;
  logic       flush;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       wb_wen;
  logic       wb_is_load;
  logic       issue_ready;
  logic       stall;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
    output issue_rd, issue_wb_en, issue_is_load, flush,
    output wb_valid, wb_rd, wb_wen, wb_is_load,
    input  issue_ready, stall
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
    input  issue_rd, issue_wb_en, issue_is_load, flush,
    input  wb_valid, wb_rd, wb_wen, wb_is_load,
    output issue_ready, stall
  );
endinterface

// File: rtl/scoreboard.sv
// Register scoreboard for a 5-stage pipeline: tracks in-flight writes per GPR,
// stalls only on load-use hazards and on counter saturation.
// Optional SCOREBOARD_STAT_EN adds a saturating 64-bit stall-cycle counter.
module scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic         clk,
  input  logic         rst,
  scoreboard_if.slave  sb,
`ifdef SCOREBOARD_STAT_EN
  output logic [63:0]  stall_cycles,
`endif
  output logic         err
);

  localparam int unsigned NREG     = 32;
  localparam int unsigned STAT_W   = 64;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] wcnt_q [NREG];
  logic [CNT_W-1:0] wcnt_d [NREG];
  logic [CNT_W-1:0] lcnt_q [NREG];
  logic [CNT_W-1:0] lcnt_d [NREG];
  logic             err_q;
  logic             err_d;

  logic             src1_haz_c;
  logic             src2_haz_c;
  logic             sat_haz_c;
  logic             stall_c;
  logic             accept_c;

  logic [NREG-1:0]  iss_w_c;
  logic [NREG-1:0]  iss_l_c;
  logic [NREG-1:0]  ret_w_c;
  logic [NREG-1:0]  ret_l_c;

  // One counter step: issue and retire in the same cycle cancel; retire clamps at zero.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec) begin
      n = c + CNT_W'(1);
    end else if (dec && !inc && (c != '0)) begin
      n = c - CNT_W'(1);
    end
    return n;
  endfunction

  // Hazard detection on pre-retire counter values; only loads block consumers.
  always_comb begin
    src1_haz_c = sb.issue_valid & sb.issue_rs1_used & (sb.issue_rs1 != 5'd0) &
                 (lcnt_q[sb.issue_rs1] != '0);
    src2_haz_c = sb.issue_valid & sb.issue_rs2_used & (sb.issue_rs2 != 5'd0) &
                 (lcnt_q[sb.issue_rs2] != '0);
    sat_haz_c  = sb.issue_valid & sb.issue_wb_en & (sb.issue_rd != 5'd0) &
                 (wcnt_q[sb.issue_rd] == CNT_MAX);
    stall_c    = (src1_haz_c | src2_haz_c | sat_haz_c) & ~sb.flush;
    accept_c   = sb.issue_valid & ~stall_c & ~sb.flush;
  end

  assign sb.stall       = stall_c;
  assign sb.issue_ready = accept_c;
  assign err            = err_q;

  // Per-register issue/retire event decode; x0 is never tracked.
  always_comb begin
    iss_w_c = '0;
    iss_l_c = '0;
    ret_w_c = '0;
    ret_l_c = '0;
    for (int r = 1; r < NREG; r++) begin
      iss_w_c[r] = accept_c & sb.issue_wb_en & (sb.issue_rd == 5'(r));
      iss_l_c[r] = iss_w_c[r] & sb.issue_is_load;
      ret_w_c[r] = sb.wb_valid & sb.wb_wen & (sb.wb_rd == 5'(r));
      ret_l_c[r] = ret_w_c[r] & sb.wb_is_load;
    end
  end

  // Counter next-state and sticky underflow detection.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < NREG; r++) begin
      wcnt_d[r] = cnt_step(wcnt_q[r], iss_w_c[r], ret_w_c[r]);
      lcnt_d[r] = cnt_step(lcnt_q[r], iss_l_c[r], ret_l_c[r]);
      if ((ret_w_c[r] && !iss_w_c[r] && (wcnt_q[r] == '0)) ||
          (ret_l_c[r] && !iss_l_c[r] && (lcnt_q[r] == '0))) begin
        err_d = 1'b1;
      end
    end
  end

  // Counter and error state registers; reset wins over any same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        wcnt_q[r] <= '0;
        lcnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      lcnt_q <= lcnt_d;
      err_q  <= err_d;
    end
  end

`ifdef SCOREBOARD_STAT_EN
  logic [STAT_W-1:0] stall_cycles_q;
  logic [STAT_W-1:0] stall_cycles_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STAT_W'(1);
    end
  end

  // Stall statistics register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_scoreboard.sv
// Cycle-by-cycle directed vectors for the scoreboard; each record is one clock
// of inputs with the combinational stall/issue_ready and registered err expected in it.
module tb_scoreboard;

  logic clk;
  logic rst;
  logic err;
`ifdef SCOREBOARD_STAT_EN
  logic [63:0] stall_cycles;
`endif

  scoreboard_if sb_if();

  scoreboard #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sb           (sb_if),
`ifdef SCOREBOARD_STAT_EN
    .stall_cycles (stall_cycles),
`endif
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic       fl;
    logic       wv;
    logic [4:0] wrd;
    logic       wwen;
    logic       wld;
    logic       e_stall;
    logic       e_ready;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic iv,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd, input logic wen, input logic ld,
                              input logic fl, input logic wv, input logic [4:0] wrd,
                              input logic wwen, input logic wld,
                              input logic es, input logic er, input logic ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.wen = wen; v.ld = ld; v.fl = fl; v.wv = wv; v.wrd = wrd;
    v.wwen = wwen; v.wld = wld; v.e_stall = es; v.e_ready = er; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst                  = v.rst;
    sb_if.issue_valid    = v.iv;
    sb_if.issue_rs1      = v.rs1;
    sb_if.issue_rs1_used = v.u1;
    sb_if.issue_rs2      = v.rs2;
    sb_if.issue_rs2_used = v.u2;
    sb_if.issue_rd       = v.rd;
    sb_if.issue_wb_en    = v.wen;
    sb_if.issue_is_load  = v.ld;
    sb_if.flush          = v.fl;
    sb_if.wb_valid       = v.wv;
    sb_if.wb_rd          = v.wrd;
    sb_if.wb_wen         = v.wwen;
    sb_if.wb_is_load     = v.wld;
  endtask

  initial begin
    // Load-use: load x5, add x6,x5,x1 stalls until the load retires (index 3), accepted at 4.
    vecs.push_back(mk(0,1, 0,0, 0,0, 5,1,1, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 5,1, 1,1, 6,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,1, 5,1, 1,1, 6,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,1, 5,1, 1,1, 6,1,0, 0, 1,5,1,1, 1,0,0));
    vecs.push_back(mk(0,1, 5,1, 1,1, 6,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,6,1,0, 0,0,0));
    // ALU producer then consumer: forwarding covers it, no stall.
    vecs.push_back(mk(0,1, 0,1, 0,0, 7,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 7,1, 0,0, 8,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,7,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,8,1,0, 0,0,0));
    // wcnt[7] back at 0: exactly three more writers fit before saturation.
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 7,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,7,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,7,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,7,1,0, 0,0,0));
    // Saturation on x9: fourth writer waits for a retire, released the cycle after.
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 1,9,1,0, 1,0,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 9,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,9,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,9,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,9,1,0, 0,0,0));
    // Flushed load leaves counters alone, so its consumer does not stall.
    vecs.push_back(mk(0,1, 0,0, 0,0, 10,1,1, 1, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1, 10,1, 0,0, 11,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,11,1,0, 0,0,0));
    // rs2 hazard, unused rs1 ignored, flush masks stall.
    vecs.push_back(mk(0,1, 0,0, 0,0, 12,1,1, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 12,0, 0,1, 0,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 12,1, 0,1,0, 1, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1, 0,0, 12,1, 0,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,1, 0,0, 12,1, 0,1,0, 0, 1,12,1,1, 1,0,0));
    vecs.push_back(mk(0,1, 0,0, 12,1, 0,1,0, 0, 0,0,0,0, 0,1,0));
    // x0 is never tracked: load to x0, consumer of x0, retire of x0.
    vecs.push_back(mk(0,1, 0,0, 0,0, 0,1,1, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,1, 0,1, 0,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,0,1,1, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 0,0,0,0, 0,0,0));
    // Same-cycle issue+retire on x14 nets out: count 1, then two more fit, fourth stalls.
    vecs.push_back(mk(0,1, 0,0, 0,0, 14,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 14,1,0, 0, 1,14,1,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 14,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 14,1,0, 0, 0,0,0,0, 0,1,0));
    vecs.push_back(mk(0,1, 0,0, 0,0, 14,1,0, 0, 0,0,0,0, 1,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,14,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,14,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,14,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 0,0,0,0, 0,0,0));
    // Underflow on x4 sets sticky err; rst mid-stall clears everything.
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 1,4,1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0,0, 0, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,1, 0,0, 0,0, 4,1,1, 0, 0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,1, 4,1, 0,0, 0,1,0, 0, 0,0,0,0, 1,0,1));
    vecs.push_back(mk(1,1, 4,1, 0,0, 0,1,0, 0, 0,0,0,0, 1,0,1));
    vecs.push_back(mk(0,1, 4,1, 0,0, 0,1,0, 0, 0,0,0,0, 0,1,0));

    apply(mk(1,0, 0,0, 0,0, 0,0,0, 0, 0,0,0,0, 0,0,0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", 0, sb_if.stall, 1'b0);
    chk("rst_ready", 0, sb_if.issue_ready, 1'b0);
    chk("rst_err", 0, err, 1'b0);
`ifdef SCOREBOARD_STAT_EN
    total++;
    if (stall_cycles !== 64'd0) begin
      bad++;
      $display("FAIL rst_stall_cycles got=%0d want=0", stall_cycles);
    end
`endif
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk("stall", i, sb_if.stall, vecs[i].e_stall);
      chk("issue_ready", i, sb_if.issue_ready, vecs[i].e_ready);
      chk("err", i, err, vecs[i].e_err);
`ifdef SCOREBOARD_STAT_EN
      if (i == 5) begin
        total++;
        if (stall_cycles !== 64'd3) begin
          bad++;
          $display("FAIL stall_cycles[%0d] got=%0d want=3", i, stall_cycles);
        end
      end
`endif
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
